seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Scan controller for the 8-digit multiplexed 7-segment display. Owns the seg/digit pins:
//   steps a one-hot digit strobe through 8 slots, with a blanking gap at the start of each slot.
//   Decodes one hex nibble per slot.
//   Producers load a new 8-digit frame over a valid/ready handshake. The frame is double-buffered
//   and becomes visible only at a frame boundary, so the display never shows a torn frame.
// PARAMETERS
//   TICK_DIV   12500  clk cycles per digit slot; must be >= BLANK_CYC+2
//   BLANK_CYC  16     cycles at start of each slot with all digits/segments inactive (ghosting guard)
//   SEG_POL    1      1: segment on = 1; 0: segment on = 0 (seg inverted)
//   DIG_POL    1      1: digit enabled = 1; 0: digit enabled = 0 (digit inverted)
// PORTS
//   clk        in   1   system clock
//   rstb       in   1   reset; synchronous, active-high
//   wr_valid   in   1   producer offers a frame
//   wr_ready   out  1   pending buffer empty; a frame is accepted when wr_valid && wr_ready
//   wr_data    in   32  nibble i (bits 4i+3:4i) is shown on digit i
//   wr_dp      in   8   bit i = decimal point of digit i
//   wr_blank   in   8   bit i = digit i is dark for its whole slot
//   seg        out  8   {dp,g,f,e,d,c,b,a}, after SEG_POL
//   digit      out  8   one-hot digit enable, bit i = digit i, after DIG_POL
//   frame_start out 1   1-cycle pulse on the first cycle of slot 0
// BEHAVIOUR
//   Interface: one clock clk; reset rstb is synchronous and active-high.
//   Reset (rstb=1 at an edge) sets:
//     - cnt=0, idx=0
//     - active data=0, dp=0, blank=8'hFF; pending buffer empty
//     - seg and digit all-inactive (per polarity); wr_ready=0; frame_start=0
//   Timing and sequencing:
//     - seg, digit and frame_start are flop outputs and reflect the (idx,cnt) held in the same cycle.
//     - cnt counts 0..TICK_DIV-1. At cnt=TICK_DIV-1, cnt wraps to 0 and idx increments; idx wraps 7->0.
//     - Boundary cycle: cnt=TICK_DIV-1 and idx=7.
//   Per-slot FSM:
//     BLANK (cnt < BLANK_CYC):
//       - all digits and all segments inactive
//     DRIVE (cnt >= BLANK_CYC):
//       - digit = one-hot(idx)
//       - seg = {dp[idx], hex7(nib[idx])}
//       - if blank[idx]=1, digit and seg stay inactive for the whole slot
//   hex7 values, active-high {g..a}: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39
//     d=5E E=79 F=71
//   Handshake:
//     - wr_ready = !pending_full, except forced 0 in reset.
//     - An accepted beat stores into pending and sets pending_full. wr_ready drops on the next cycle.
//     - At the boundary cycle with pending_full=1:
//       - pending is copied to active; pending_full clears
//       - the new frame is displayed from slot 0 onward; wr_ready=1 on the next cycle
//     - Beat accepted on a boundary cycle while pending was empty: it goes to pending only, and is
//       shown from the following frame onward.
//     - wr_data/wr_dp/wr_blank are sampled only on acceptance. Holding wr_valid with no acceptance
//       has no effect.
//   frame_start:
//     - high when idx=0 and cnt=0, including the first cycle after reset release
//     - period 8*TICK_DIV cycles
//   Reset mid-slot or mid-handshake:
//     - the pending frame is discarded
//     - outputs go inactive on the cycle after the reset edge; scanning restarts at slot 0
//   Counter width is $clog2(TICK_DIV). There is no other arithmetic, and overflow is impossible by
//   construction.
// TESTING (TICK_DIV=8, BLANK_CYC=2, SEG_POL=DIG_POL=1 unless stated)
//   1 Reset, release, no writes:
//       -> digit=00 and seg=00 for 64+ cycles (all blank)
//       -> wr_ready=1 from the first cycle after release
//       -> frame_start high every 64 cycles, starting with the first cycle after release
//   2 Write data=76543210, dp=01, blank=00 in the first frame:
//       -> accepted in 1 cycle
//       -> next frame, slot0 cnt2..7: digit=01, seg=BF
//       -> slot1: digit=02, seg=06
//       -> slot7: digit=80, seg=07
//       -> slot0 cnt0..1: digit=00, seg=00
//   3 Second write (data=FFFFFFFF) held valid right after write 2:
//       -> wr_ready=0 until the cycle after the boundary; the beat is then accepted
//       -> write 2 is shown for exactly one frame, then F (seg=71) on all digits; no beat lost
//   4 Write data=00000008, blank=FE on a boundary cycle:
//       -> not shown in the next frame
//       -> shown in the frame after: slot0 seg=7F digit=01; slots1-7 digit=00
//   5 rstb=1 for 1 cycle at slot 3, cnt=5, with a frame pending:
//       -> next cycle digit=00, seg=00
//       -> scan restarts at slot 0; pending frame is never displayed
//   6 SEG_POL=0, DIG_POL=0, repeat test 2:
//       -> slot0 DRIVE: digit=FE, seg=40
//       -> BLANK: digit=FF, seg=FF
//       -> reset: digit=FF, seg=FF

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 8-digit multiplexed 7-segment scan controller with double-buffered frame load
module seg_scan_ctrl #(
    parameter int TICK_DIV  = 12500,
    parameter int BLANK_CYC = 16,
    parameter bit SEG_POL   = 1'b1,
    parameter bit DIG_POL   = 1'b1
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_blank,
    output logic [7:0]  seg,
    output logic [7:0]  digit,
    output logic        frame_start
);

    localparam int               CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [7:0]       SEG_OFF   = SEG_POL ? 8'h00 : 8'hFF;
    localparam logic [7:0]       DIG_OFF   = DIG_POL ? 8'h00 : 8'hFF;

    // ST_IDLE is held only between the reset edge and the first running edge
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [31:0]       act_data_q, act_data_d;
    logic [7:0]        act_dp_q, act_dp_d;
    logic [7:0]        act_blank_q, act_blank_d;
    logic [31:0]       pend_data_q, pend_data_d;
    logic [7:0]        pend_dp_q, pend_dp_d;
    logic [7:0]        pend_blank_q, pend_blank_d;
    logic              pend_full_q, pend_full_d;
    logic              wr_ready_q, wr_ready_d;
    logic [7:0]        seg_q, seg_d;
    logic [7:0]        digit_q, digit_d;
    logic              frame_start_q, frame_start_d;

    logic              accept;
    logic              boundary;
    logic [3:0]        nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        act_blank_d   = act_blank_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        pend_full_d   = pend_full_q;
        seg_d         = SEG_OFF;
        digit_d       = DIG_OFF;
        nib           = 4'h0;

        accept   = wr_valid && wr_ready_q;
        boundary = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && (idx_q == 3'd7);

        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            idx_d = 3'd0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Swap before accepting: a beat taken on the boundary lands in pending only
        if (boundary && pend_full_q) begin
            act_data_d  = pend_data_q;
            act_dp_d    = pend_dp_q;
            act_blank_d = pend_blank_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_data_d  = wr_data;
            pend_dp_d    = wr_dp;
            pend_blank_d = wr_blank;
            pend_full_d  = 1'b1;
        end

        state_d    = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_DRIVE;
        wr_ready_d = !pend_full_d;

        // Outputs are registered from next-state so they line up with the held (idx,cnt)
        nib = 4'(act_data_d >> {idx_d, 2'b00});
        if ((state_d == ST_DRIVE) && !act_blank_d[idx_d]) begin
            seg_d   = {act_dp_d[idx_d], hex7(nib)} ^ SEG_OFF;
            digit_d = (8'h01 << idx_d) ^ DIG_OFF;
        end
        frame_start_d = (cnt_d == '0) && (idx_d == 3'd0);
    end

    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            act_data_q    <= 32'h0;
            act_dp_q      <= 8'h00;
            act_blank_q   <= 8'hFF;
            pend_data_q   <= 32'h0;
            pend_dp_q     <= 8'h00;
            pend_blank_q  <= 8'h00;
            pend_full_q   <= 1'b0;
            wr_ready_q    <= 1'b0;
            seg_q         <= SEG_OFF;
            digit_q       <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_full_q   <= pend_full_d;
            wr_ready_q    <= wr_ready_d;
            seg_q         <= seg_d;
            digit_q       <= digit_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign seg         = seg_q;
    assign digit       = digit_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (both polarities in parallel)
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rstb = 1'b1;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic [7:0]  wr_dp = 8'h0;
    logic [7:0]  wr_blank = 8'h0;
    logic        wr_ready, wr_ready_n;
    logic        frame_start, frame_start_n;
    logic [7:0]  seg, digit, seg_n, digit_n;

    seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2), .SEG_POL(1'b1), .DIG_POL(1'b1)) dut (
        .clk(clk), .rstb(rstb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
        .seg(seg), .digit(digit), .frame_start(frame_start)
    );

    seg_scan_ctrl #(.TICK_DIV(8), .BLANK_CYC(2), .SEG_POL(1'b0), .DIG_POL(1'b0)) dut_n (
        .clk(clk), .rstb(rstb), .wr_valid(wr_valid), .wr_ready(wr_ready_n),
        .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
        .seg(seg_n), .digit(digit_n), .frame_start(frame_start_n)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] HEX7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
    } frame_t;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        int          slot;
        logic [7:0]  exp_seg;
        logic [7:0]  exp_dig;
    } vec_t;

    int     n_chk = 0;
    int     n_fail = 0;
    int     m_t = 0;
    frame_t m_act;
    frame_t m_pend[$];
    vec_t   vecs[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %h, want %h", name, m_t, act, exp);
        end
    endtask

    task automatic model_reset();
        m_t   = 0;
        m_act = '{32'h0, 8'h00, 8'hFF};
        m_pend.delete();
    endtask

    // Expected pins from cycle position within the frame and the visible frame
    task automatic check_now();
        int         slot;
        int         c;
        logic [7:0] es;
        logic [7:0] ed;
        logic [3:0] nib;
        slot = (m_t / 8) % 8;
        c    = m_t % 8;
        es   = 8'h00;
        ed   = 8'h00;
        if (c >= 2 && !m_act.blank[slot]) begin
            nib = m_act.data[slot*4 +: 4];
            ed  = 8'h01 << slot;
            es  = {m_act.dp[slot], HEX7[nib]};
        end
        chk("seg", seg, es);
        chk("digit", digit, ed);
        chk("seg_inv", seg_n, ~es);
        chk("digit_inv", digit_n, ~ed);
        chk("frame_start", 8'(frame_start), 8'(m_t % 64 == 0));
        chk("frame_start_inv", 8'(frame_start_n), 8'(m_t % 64 == 0));
        chk("wr_ready", 8'(wr_ready), 8'(m_pend.size() == 0));
        chk("wr_ready_inv", 8'(wr_ready_n), 8'(m_pend.size() == 0));
    endtask

    task automatic cycle();
        bit     acc;
        frame_t f;
        check_now();
        acc = wr_valid && (m_pend.size() == 0);
        f   = '{wr_data, wr_dp, wr_blank};
        @(posedge clk);
        if (m_t % 64 == 63 && m_pend.size() != 0) m_act = m_pend.pop_front();
        if (acc) m_pend.push_back(f);
        m_t++;
        @(negedge clk);
    endtask

    task automatic run_to(input int t);
        while (m_t < t) cycle();
    endtask

    task automatic do_reset(input int n);
        rstb     = 1'b1;
        wr_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_seg", seg, 8'h00);
            chk("rst_digit", digit, 8'h00);
            chk("rst_seg_inv", seg_n, 8'hFF);
            chk("rst_digit_inv", digit_n, 8'hFF);
            chk("rst_ready", 8'(wr_ready), 8'h00);
            chk("rst_frame_start", 8'(frame_start), 8'h00);
        end
        rstb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
    endtask

    task automatic put(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = dp;
        wr_blank = bl;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{32'h76543210, 8'h01, 8'h00, 0, 8'hBF, 8'h01};
        vecs[1]  = '{32'h76543210, 8'h01, 8'h00, 1, 8'h06, 8'h02};
        vecs[2]  = '{32'h76543210, 8'h01, 8'h00, 7, 8'h07, 8'h80};
        vecs[3]  = '{32'h00000008, 8'h00, 8'hFE, 0, 8'h7F, 8'h01};
        vecs[4]  = '{32'h00000008, 8'h00, 8'hFE, 3, 8'h00, 8'h00};
        vecs[5]  = '{32'hFFFFFFFF, 8'h00, 8'h00, 5, 8'h71, 8'h20};
        vecs[6]  = '{32'hA5C3E1B9, 8'h80, 8'h00, 7, 8'hF7, 8'h80};
        vecs[7]  = '{32'hA5C3E1B9, 8'h80, 8'h00, 3, 8'h79, 8'h08};
        vecs[8]  = '{32'h89ABCDEF, 8'h10, 8'h00, 4, 8'hFC, 8'h10};
        vecs[9]  = '{32'h89ABCDEF, 8'h10, 8'h10, 4, 8'h00, 8'h00};
        vecs[10] = '{32'h89ABCDEF, 8'h10, 8'h10, 2, 8'h5E, 8'h04};

        // Idle after reset: dark, ready, frame_start every 64 cycles
        do_reset(3);
        chk("fs_first", 8'(frame_start), 8'h01);
        chk("ready_first", 8'(wr_ready), 8'h01);
        run_to(140);

        foreach (vecs[i]) begin
            do_reset(2);
            put(vecs[i].data, vecs[i].dp, vecs[i].blank);
            cycle();
            wr_valid = 1'b0;
            chk("vec_ready_drop", 8'(wr_ready), 8'h00);
            run_to(64 + vecs[i].slot * 8 + 4);
            chk("vec_seg", seg, vecs[i].exp_seg);
            chk("vec_digit", digit, vecs[i].exp_dig);
            chk("vec_seg_inv", seg_n, ~vecs[i].exp_seg);
            chk("vec_digit_inv", digit_n, ~vecs[i].exp_dig);
            run_to(64 + vecs[i].slot * 8 + 1);
        end

        // Second beat held valid behind the first
        do_reset(2);
        put(32'h76543210, 8'h01, 8'h00);
        cycle();
        put(32'hFFFFFFFF, 8'h00, 8'h00);
        run_to(63);
        chk("hold_ready_boundary", 8'(wr_ready), 8'h00);
        cycle();
        chk("hold_ready_after", 8'(wr_ready), 8'h01);
        cycle();
        wr_valid = 1'b0;
        chk("hold_ready_drop", 8'(wr_ready), 8'h00);
        run_to(124);
        chk("hold_old_frame_seg", seg, 8'h07);
        run_to(132);
        chk("hold_new_frame_seg", seg, 8'h71);
        chk("hold_new_frame_digit", digit, 8'h01);
        run_to(200);

        // Beat accepted on the boundary shows one frame later
        do_reset(2);
        run_to(63);
        put(32'h00000008, 8'h00, 8'hFE);
        cycle();
        wr_valid = 1'b0;
        run_to(68);
        chk("bnd_not_yet_digit", digit, 8'h00);
        run_to(132);
        chk("bnd_shown_seg", seg, 8'h7F);
        chk("bnd_shown_digit", digit, 8'h01);
        run_to(140);
        chk("bnd_slot1_digit", digit, 8'h00);

        // Reset mid-slot with a frame pending
        do_reset(2);
        put(32'h76543210, 8'h01, 8'h00);
        cycle();
        wr_valid = 1'b0;
        run_to(64);
        put(32'hFFFFFFFF, 8'h00, 8'h00);
        cycle();
        wr_valid = 1'b0;
        run_to(93);
        do_reset(1);
        chk("midrst_fs", 8'(frame_start), 8'h01);
        run_to(76);
        chk("midrst_digit", digit, 8'h00);
        run_to(140);

        // Random traffic with occasional resets
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset($urandom_range(1, 2));
            end else begin
                if (!wr_valid || $urandom_range(0, 2) == 0) wr_valid = ($urandom_range(0, 2) == 0);
                wr_data  = $urandom;
                wr_dp    = 8'($urandom);
                wr_blank = 8'($urandom) & 8'($urandom);
                cycle();
            end
        end
        wr_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
